uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable word length, parity and stop bits.
// Samples each bit at its centre using the clken tick; delivers words with rdy/overrun handshake.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 clken,
    input  logic                 rdy_clr,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SAMPLE_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMPLE_END = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP  = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic                 rx_meta_q, rx_s_q;
    state_t               state_q, state_d;
    logic [SW-1:0]        sample_q, sample_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] scratch_q, scratch_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 rdy_q, rdy_d;
    logic                 overrun_q, overrun_d;
    logic                 deliver;
    logic                 par_xor;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        sample_d   = sample_q;
        bitcnt_d   = bitcnt_q;
        scratch_d  = scratch_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        deliver    = 1'b0;
        par_xor    = ^{scratch_q, rx_s_q};

        if (clken) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d  = S_START;
                        sample_d = '0;
                        perr_d   = 1'b0;
                        ferr_d   = 1'b0;
                    end
                end
                S_START: begin
                    if (sample_q == SAMPLE_MID) begin
                        sample_d = '0;
                        if (!rx_s_q) begin
                            state_d  = S_DATA;
                            bitcnt_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (sample_q == SAMPLE_END) begin
                        sample_d  = '0;
                        scratch_d = {rx_s_q, scratch_q[DATA_BITS-1:1]};
                        if (bitcnt_q == LAST_DATA) begin
                            bitcnt_d = '0;
                            state_d  = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (sample_q == SAMPLE_END) begin
                        sample_d = '0;
                        perr_d   = (PARITY == 1) ? ~par_xor : par_xor;
                        state_d  = S_STOP;
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (sample_q == SAMPLE_END) begin
                        sample_d = '0;
                        ferr_d   = ferr_q | ~rx_s_q;
                        if (bitcnt_q == LAST_STOP) begin
                            // Deliver with the error flag that includes this final stop sample.
                            bitcnt_d   = '0;
                            deliver    = 1'b1;
                            data_d     = scratch_q;
                            perr_out_d = perr_q;
                            ferr_out_d = ferr_d;
                            state_d    = ferr_d ? S_BREAK : S_IDLE;
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Delivery outranks a simultaneous acknowledge.
    always_comb begin
        rdy_d     = rdy_q;
        overrun_d = overrun_q;
        if (deliver) begin
            rdy_d     = 1'b1;
            overrun_d = overrun_q | (rdy_q & ~rdy_clr);
        end else if (rdy_clr) begin
            rdy_d     = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            sample_q   <= '0;
            bitcnt_q   <= '0;
            scratch_q  <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            rdy_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            sample_q   <= sample_d;
            bitcnt_q   <= bitcnt_d;
            scratch_q  <= scratch_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            rdy_q      <= rdy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rdy        = rdy_q;
    assign data       = data_q;
    assign parity_err = (PARITY != 0) ? perr_out_q : 1'b0;
    assign frame_err  = ferr_out_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default, even-parity, and 7-bit/2-stop instances.
// Frames come from a vector table plus hand-written sequences for timing and error corners.
module tb_uart_rx_param;

    localparam int OS = 16;

    logic       clk_ = 1'b0;
    logic       rst = 1'b1;
    logic       clken = 1'b0;
    logic       rdy_clr = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

    logic       rdy_a, perr_a, ferr_a, ovr_a, busy_a;
    logic [7:0] data_a;
    logic       rdy_b, perr_b, ferr_b, ovr_b, busy_b;
    logic [7:0] data_b;
    logic       rdy_c, perr_c, ferr_c, ovr_c, busy_c;
    logic [6:0] data_c;

    int checks = 0;
    int failures = 0;
    int clken_div = 1;
    int tick_cnt = 0;
    int rise_a = 0;
    logic rdy_a_prev = 1'b0;

    uart_rx_param u_a (
        .clk_(clk_), .rst(rst), .rx(rx_a), .clken(clken), .rdy_clr(rdy_clr),
        .rdy(rdy_a), .data(data_a), .parity_err(perr_a), .frame_err(ferr_a),
        .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_param #(.PARITY(2)) u_b (
        .clk_(clk_), .rst(rst), .rx(rx_b), .clken(clken), .rdy_clr(rdy_clr),
        .rdy(rdy_b), .data(data_b), .parity_err(perr_b), .frame_err(ferr_b),
        .overrun(ovr_b), .busy(busy_b)
    );

    uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_c (
        .clk_(clk_), .rst(rst), .rx(rx_c), .clken(clken), .rdy_clr(rdy_clr),
        .rdy(rdy_c), .data(data_c), .parity_err(perr_c), .frame_err(ferr_c),
        .overrun(ovr_c), .busy(busy_c)
    );

    always #5 clk_ = ~clk_;

    always @(negedge clk_) begin
        if (tick_cnt >= clken_div - 1) begin
            tick_cnt = 0;
            clken = 1'b1;
        end else begin
            tick_cnt = tick_cnt + 1;
            clken = 1'b0;
        end
    end

    always @(negedge clk_) begin
        if (rdy_a && !rdy_a_prev) rise_a = rise_a + 1;
        rdy_a_prev = rdy_a;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         sel;
        logic [8:0] d;
        int         nbits;
        bit         has_par;
        logic       pbit;
        logic [1:0] stop;
        int         nstop;
        int         div;
        logic [8:0] exp_d;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic get_out(input int sel, output logic r, output logic [8:0] d,
                           output logic pe, output logic fe, output logic ov, output logic bz);
        case (sel)
            0: begin r = rdy_a; d = {1'b0, data_a}; pe = perr_a; fe = ferr_a; ov = ovr_a; bz = busy_a; end
            1: begin r = rdy_b; d = {1'b0, data_b}; pe = perr_b; fe = ferr_b; ov = ovr_b; bz = busy_b; end
            default: begin r = rdy_c; d = {2'b0, data_c}; pe = perr_c; fe = ferr_c; ov = ovr_c; bz = busy_c; end
        endcase
    endtask

    task automatic drive_bit(input int sel, input logic v);
        set_rx(sel, v);
        repeat (OS * clken_div) @(negedge clk_);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * OS * clken_div) @(negedge clk_);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] d, input int nbits, input bit has_par,
                              input logic pbit, input logic [1:0] stop, input int nstop,
                              input logic idle_lvl);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, pbit);
        for (int i = 0; i < nstop; i++) drive_bit(sel, stop[i]);
        set_rx(sel, idle_lvl);
    endtask

    task automatic wait_rdy(input int sel, output bit ok);
        logic r, pe, fe, ov, bz;
        logic [8:0] d;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            get_out(sel, r, d, pe, fe, ov, bz);
            if (r) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_);
        end
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        @(negedge clk_);
        rdy_clr = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        logic r, pe, fe, ov, bz;
        logic [8:0] d;
        bit ok;
        int cyc;
        int base;
        int n;
        bit saw_busy;
        bit saw_rdy;

        vecs[0] = '{0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, 1, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h03C, 8, 0, 1'b0, 2'b11, 1, 3, 9'h03C, 1'b0, 1'b0};
        vecs[2] = '{0, 9'h081, 8, 0, 1'b0, 2'b00, 1, 1, 9'h081, 1'b0, 1'b1};
        vecs[3] = '{1, 9'h037, 8, 1, 1'b0, 2'b11, 1, 1, 9'h037, 1'b1, 1'b0};
        vecs[4] = '{1, 9'h037, 8, 1, 1'b1, 2'b11, 1, 1, 9'h037, 1'b0, 1'b0};
        vecs[5] = '{1, 9'h0FF, 8, 1, 1'b0, 2'b11, 1, 1, 9'h0FF, 1'b0, 1'b0};
        vecs[6] = '{1, 9'h001, 8, 1, 1'b0, 2'b11, 1, 1, 9'h001, 1'b1, 1'b0};
        vecs[7] = '{2, 9'h04A, 7, 0, 1'b0, 2'b11, 2, 1, 9'h04A, 1'b0, 1'b0};
        vecs[8] = '{2, 9'h00F, 7, 0, 1'b0, 2'b01, 2, 1, 9'h00F, 1'b0, 1'b1};

        // Reset state of all three instances.
        repeat (3) @(negedge clk_);
        for (int s = 0; s < 3; s++) begin
            get_out(s, r, d, pe, fe, ov, bz);
            check($sformatf("rst_rdy%0d", s), {31'b0, r}, 32'd0);
            check($sformatf("rst_data%0d", s), {23'b0, d}, 32'd0);
            check($sformatf("rst_flags%0d", s), {28'b0, pe, fe, ov, bz}, 32'd0);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk_);

        // Latency from rx falling edge to rdy.
        cyc = 0;
        fork
            send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, 1'b1);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk_);
                    #1;
                    cyc++;
                    if (rdy_a) break;
                end
            end
        join
        check("lat_in_range", {31'b0, (cyc >= 149 && cyc <= 155)}, 32'd1);
        check("lat_data", {24'b0, data_a}, 32'h0A5);
        check("lat_ferr", {31'b0, ferr_a}, 32'd0);
        pulse_clr();
        idle_bits(1);

        // Table-driven frames.
        for (int v = 0; v < 9; v++) begin
            clken_div = vecs[v].div;
            send_frame(vecs[v].sel, vecs[v].d, vecs[v].nbits, vecs[v].has_par, vecs[v].pbit,
                       vecs[v].stop, vecs[v].nstop, 1'b1);
            wait_rdy(vecs[v].sel, ok);
            get_out(vecs[v].sel, r, d, pe, fe, ov, bz);
            check($sformatf("v%0d_rdy", v), {31'b0, ok}, 32'd1);
            check($sformatf("v%0d_data", v), {23'b0, d}, {23'b0, vecs[v].exp_d});
            check($sformatf("v%0d_perr", v), {31'b0, pe}, {31'b0, vecs[v].exp_perr});
            check($sformatf("v%0d_ferr", v), {31'b0, fe}, {31'b0, vecs[v].exp_ferr});
            pulse_clr();
            get_out(vecs[v].sel, r, d, pe, fe, ov, bz);
            check($sformatf("v%0d_clr", v), {30'b0, r, ov}, 32'd0);
            idle_bits(2);
            get_out(vecs[v].sel, r, d, pe, fe, ov, bz);
            check($sformatf("v%0d_idle", v), {31'b0, bz}, 32'd0);
            clken_div = 1;
        end

        // False start: 5 low ticks then high.
        saw_busy = 1'b0;
        saw_rdy = 1'b0;
        rx_a = 1'b0;
        repeat (5) begin
            @(negedge clk_);
            if (busy_a) saw_busy = 1'b1;
        end
        rx_a = 1'b1;
        n = 0;
        while (busy_a && n < OS / 2 + 3) begin
            @(negedge clk_);
            n++;
        end
        check("fs_entered", {31'b0, saw_busy}, 32'd1);
        check("fs_busy_clear", {31'b0, busy_a}, 32'd0);
        repeat (40) begin
            @(negedge clk_);
            if (rdy_a) saw_rdy = 1'b1;
        end
        check("fs_no_rdy", {31'b0, saw_rdy}, 32'd0);

        // Line held low after a framing error: one delivery only.
        base = rise_a;
        send_frame(0, 9'h000, 8, 0, 1'b0, 2'b00, 1, 1'b0);
        idle_bits(40);
        check("brk_one_delivery", rise_a - base, 32'd1);
        check("brk_data", {24'b0, data_a}, 32'h00);
        check("brk_ferr", {31'b0, ferr_a}, 32'd1);
        check("brk_no_overrun", {31'b0, ovr_a}, 32'd0);
        check("brk_busy_low", {31'b0, busy_a}, 32'd1);
        rx_a = 1'b1;
        idle_bits(2);
        check("brk_released", {31'b0, busy_a}, 32'd0);
        pulse_clr();
        send_frame(0, 9'h05A, 8, 0, 1'b0, 2'b11, 1, 1'b1);
        wait_rdy(0, ok);
        check("brk_next_rdy", {31'b0, ok}, 32'd1);
        check("brk_next_data", {24'b0, data_a}, 32'h5A);
        check("brk_next_ferr", {31'b0, ferr_a}, 32'd0);
        check("brk_two_total", rise_a - base, 32'd2);
        pulse_clr();
        idle_bits(1);

        // Overrun: two frames with no acknowledge.
        send_frame(0, 9'h011, 8, 0, 1'b0, 2'b11, 1, 1'b1);
        idle_bits(1);
        send_frame(0, 9'h022, 8, 0, 1'b0, 2'b11, 1, 1'b1);
        idle_bits(1);
        check("ovr_rdy", {31'b0, rdy_a}, 32'd1);
        check("ovr_data", {24'b0, data_a}, 32'h22);
        check("ovr_flag", {31'b0, ovr_a}, 32'd1);
        pulse_clr();
        check("ovr_clr", {30'b0, rdy_a, ovr_a}, 32'd0);
        check("ovr_data_hold", {24'b0, data_a}, 32'h22);

        // Reset mid-frame on the 7-bit / 2-stop instance.
        drive_bit(2, 1'b0);
        drive_bit(2, 1'b1);
        drive_bit(2, 1'b1);
        drive_bit(2, 1'b0);
        rst = 1'b1;
        rx_c = 1'b1;
        repeat (2) @(negedge clk_);
        rst = 1'b0;
        idle_bits(12);
        check("abort_rdy", {31'b0, rdy_c}, 32'd0);
        check("abort_busy", {31'b0, busy_c}, 32'd0);
        check("abort_data", {25'b0, data_c}, 32'd0);
        send_frame(2, 9'h055, 7, 0, 1'b0, 2'b11, 2, 1'b1);
        wait_rdy(2, ok);
        check("clean_rdy", {31'b0, ok}, 32'd1);
        check("clean_data", {25'b0, data_c}, 32'h55);
        check("clean_ferr", {31'b0, ferr_c}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
